// File: rtl/interval_arbiter.sv
// Round-robin sequencer sharing one load-or-decrement down-counter
// between two requesters that each need a timed interval.
module interval_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dur0,
  input  logic [WIDTH-1:0] dur1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy0,
  output logic             busy1,
  output logic             done0,
  output logic             done1,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_value,
  input  logic [WIDTH-1:0] cnt_q
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   win;

  // On contention the requester that did not own the last interval wins
  assign win = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    cnt_load  = 1'b1;
    cnt_value = '0;
    unique case (state_q)
      IDLE: begin
        // Grant is gated by reset so nothing leaks out while held in reset
        if (reset && (req0 || req1)) begin
          gnt0      = ~win;
          gnt1      = win;
          cnt_value = win ? dur1 : dur0;
          owner_d   = win;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) cnt_load = 1'b0;
        else             state_d  = DONE;
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy0 = (state_q != IDLE) && !owner_q;
  assign busy1 = (state_q != IDLE) &&  owner_q;
  assign done0 = (state_q == DONE) && !owner_q;
  assign done1 = (state_q == DONE) &&  owner_q;

endmodule

// File: tb/tb_interval_arbiter.sv
// Bench for interval_arbiter: a behavioural counter plus a schedule-based
// reference model that predicts every output from grant time and duration.
module tb_interval_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] dur0 = '0, dur1 = '0;
  logic       gnt0, gnt1, busy0, busy1, done0, done1;
  logic       cnt_load;
  logic [3:0] cnt_value;
  logic [3:0] cnt_q;

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int g = -100;
  int d = 0;
  bit own = 1'b0;
  bit m_last = 1'b1;

  always #5 clk = ~clk;

  interval_arbiter #(.WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .req1(req1),
    .dur0(dur0),
    .dur1(dur1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .busy0(busy0),
    .busy1(busy1),
    .done0(done0),
    .done1(done1),
    .cnt_load(cnt_load),
    .cnt_value(cnt_value),
    .cnt_q(cnt_q)
  );

  // The shared free-running counter that sits beside the arbiter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_load ? cnt_value : cnt_q - 4'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    g = -100;
    d = 0;
    own = 1'b0;
    m_last = 1'b1;
  endtask

  // Inputs for the current cycle are already applied when this is called
  task automatic tick();
    int e_g0, e_g1, e_b0, e_b1, e_d0, e_d1, e_ld, e_val, e_q;
    bit act, run, w, any;
    #1;
    e_g0 = 0; e_g1 = 0; e_b0 = 0; e_b1 = 0;
    e_d0 = 0; e_d1 = 0; e_ld = 1; e_val = 0; e_q = 0;
    any = 1'b0;
    w = 1'b0;
    act = (cyc > g) && (cyc <= g + 2 + d);
    if (act) begin
      run = (cyc <= g + 1 + d);
      e_q = run ? d - (cyc - g - 1) : 0;
      e_ld = (run && cyc < g + 1 + d) ? 0 : 1;
      if (own) e_b1 = 1;
      else     e_b0 = 1;
      if (cyc == g + 2 + d) begin
        if (own) e_d1 = 1;
        else     e_d0 = 1;
      end
    end else if (req0 || req1) begin
      any = 1'b1;
      w = (req0 && req1) ? !m_last : req1;
      e_g0 = w ? 0 : 1;
      e_g1 = w ? 1 : 0;
      e_val = w ? int'(dur1) : int'(dur0);
    end
    chk("gnt0", int'(gnt0), e_g0);
    chk("gnt1", int'(gnt1), e_g1);
    chk("busy0", int'(busy0), e_b0);
    chk("busy1", int'(busy1), e_b1);
    chk("done0", int'(done0), e_d0);
    chk("done1", int'(done1), e_d1);
    chk("cnt_load", int'(cnt_load), e_ld);
    chk("cnt_value", int'(cnt_value), e_val);
    chk("cnt_q", int'(cnt_q), e_q);
    chk("busy_excl", int'(busy0 & busy1), 0);
    if (any) begin
      g = cyc;
      d = e_val;
      own = w;
      m_last = w;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    release_reset();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_gnt0", int'(gnt0), 0);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_load", int'(cnt_load), 1);
    chk("rst_value", int'(cnt_value), 0);
    do_reset();

    // Single interval, dur 5, req dropped in the DONE cycle
    req0 = 1'b1;
    dur0 = 4'd5;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) req0 = 1'b0;
      tick();
    end
    run_n(4);

    // Both held, alternating grants
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    dur0 = 4'd2;
    dur1 = 4'd3;
    run_n(24);
    req0 = 1'b0;
    req1 = 1'b0;
    run_n(10);

    // Zero duration
    do_reset();
    req1 = 1'b1;
    dur1 = 4'd0;
    run_n(2);
    req1 = 1'b0;
    run_n(4);

    // Dur change and req drop after grant
    do_reset();
    req0 = 1'b1;
    dur0 = 4'd4;
    run_n(2);
    dur0 = 4'd9;
    req0 = 1'b0;
    run_n(8);

    // Reset mid-interval
    do_reset();
    req0 = 1'b1;
    dur0 = 4'd8;
    run_n(3);
    reset = 1'b0;
    #1;
    chk("mid_busy0", int'(busy0), 0);
    chk("mid_busy1", int'(busy1), 0);
    chk("mid_load", int'(cnt_load), 1);
    chk("mid_value", int'(cnt_value), 0);
    chk("mid_gnt0", int'(gnt0), 0);
    @(posedge clk);
    #1;
    chk("mid_done0", int'(done0), 0);
    chk("mid_cntq", int'(cnt_q), 0);
    req1 = 1'b1;
    dur0 = 4'd3;
    dur1 = 4'd2;
    release_reset();
    #1;
    chk("rearb_gnt0", int'(gnt0), 1);
    #1;
    run_n(14);
    req0 = 1'b0;
    req1 = 1'b0;
    run_n(6);

    // Long idle
    do_reset();
    run_n(20);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      dur0 = 4'($urandom_range(0, 15));
      dur1 = 4'($urandom_range(0, 15));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
